// File: rtl/i2s_tx_frame_ctrl.sv
// Transmit-side I2S frame controller: divides aud_mclk into SCLK, sequences the
// 64-slot stereo frame and serializes double-buffered sample pairs MSB-first.
module i2s_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DIV_W      = 8
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrst,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      sclk_div,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    output logic                  s_ready,
    input  logic                  irq_clr,
    output logic                  sclk_out,
    output logic                  lrclk_out,
    output logic                  sdata_0_out,
    output logic                  irq,
    output logic                  busy
);

    localparam int unsigned SLOT_W  = 32;
    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned P_W     = 6;
    localparam int unsigned PAD_W   = SLOT_W - DATA_WIDTH;

    localparam logic [P_W-1:0] P_LAST   = P_W'(FRAME_W - 1);
    localparam logic [P_W-1:0] LR_FIRST = P_W'(SLOT_W - 1);
    localparam logic [P_W-1:0] LR_LAST  = P_W'(FRAME_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [P_W-1:0]        p_q, p_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;
    logic                  s_ready_q;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  irq_q, irq_d;
    logic                  busy_q;

    logic                  active_c;
    logic                  wrap_c;
    logic                  fall_c;
    logic                  frame_tick_c;
    logic                  end_frame_c;
    logic                  xfer_c;
    logic                  underflow_c;
    logic                  accept_c;
    logic [SLOT_W-1:0]     left_slot_c;
    logic [SLOT_W-1:0]     right_slot_c;

    // Tick decode: a fall tick is the divider wrap while SCLK is high.
    assign active_c     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wrap_c       = active_c && (cnt_q == (div_q - DIV_W'(1)));
    assign fall_c       = wrap_c && sclk_q;
    assign frame_tick_c = fall_c && (p_q == P_LAST);
    assign end_frame_c  = frame_tick_c && (state_q == ST_DRAIN) && !enable;
    assign xfer_c       = frame_tick_c && !end_frame_c && hold_full_q;
    assign underflow_c  = frame_tick_c && !end_frame_c && !hold_full_q;
    assign accept_c     = s_valid && s_ready_q;

    // Samples are left-justified in their 32-bit slot, low bits zero.
    assign left_slot_c  = SLOT_W'(hold_l_q) << PAD_W;
    assign right_slot_c = SLOT_W'(hold_r_q) << PAD_W;

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PRIME;
            ST_PRIME: begin
                if (!enable)          state_d = ST_IDLE;
                else if (hold_full_q) state_d = ST_RUN;
            end
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)            state_d = ST_RUN;
                else if (frame_tick_c) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d       = div_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        shift_d     = shift_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        irq_d       = underflow_c | (irq_q & ~irq_clr);

        if ((state_q == ST_IDLE) && enable) begin
            div_d = (sclk_div == '0) ? DIV_W'(1) : sclk_div;
        end

        // Transfer takes the old contents; a same-cycle accept refills.
        if (xfer_c) begin
            hold_full_d = 1'b0;
        end
        if (accept_c) begin
            hold_l_d    = s_left;
            hold_r_d    = s_right;
            hold_full_d = 1'b1;
        end

        if (active_c && (state_d != ST_IDLE)) begin
            if (wrap_c) begin
                cnt_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (fall_c) begin
                p_d = p_q + P_W'(1);
                if (frame_tick_c) begin
                    shift_d = xfer_c ? {left_slot_c, right_slot_c} : '0;
                end
                lrclk_d = (p_d >= LR_FIRST) && (p_d <= LR_LAST);
                sdata_d = shift_d[P_LAST - p_d];
            end
        end else begin
            cnt_d   = '0;
            p_d     = P_LAST;
            sclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            div_q       <= DIV_W'(1);
            cnt_q       <= '0;
            p_q         <= P_LAST;
            shift_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            s_ready_q   <= 1'b1;
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            shift_q     <= shift_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            s_ready_q   <= ~hold_full_d;
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            irq_q       <= irq_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign s_ready     = s_ready_q;
    assign sclk_out    = sclk_q;
    assign lrclk_out   = lrclk_q;
    assign sdata_0_out = sdata_q;
    assign irq         = irq_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Directed bench for i2s_tx_frame_ctrl: table-driven single frames plus
// hand-written streaming, underflow, drain, reset and divider sequences.
module tb_i2s_tx_frame_ctrl;

    logic        aud_mclk;
    logic        aud_mrst;
    logic        enable;
    logic [7:0]  sclk_div;
    logic        s_valid;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        s_ready;
    logic        irq_clr;
    logic        sclk_out;
    logic        lrclk_out;
    logic        sdata_0_out;
    logic        irq;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [63:0] LR_PATTERN = 64'h0000_0001_FFFF_FFFE;

    i2s_tx_frame_ctrl #(.DATA_WIDTH(24), .DIV_W(8)) dut (
        .aud_mclk   (aud_mclk),
        .aud_mrst   (aud_mrst),
        .enable     (enable),
        .sclk_div   (sclk_div),
        .s_valid    (s_valid),
        .s_left     (s_left),
        .s_right    (s_right),
        .s_ready    (s_ready),
        .irq_clr    (irq_clr),
        .sclk_out   (sclk_out),
        .lrclk_out  (lrclk_out),
        .sdata_0_out(sdata_0_out),
        .irq        (irq),
        .busy       (busy)
    );

    initial aud_mclk = 1'b0;
    always #5 aud_mclk = ~aud_mclk;

    // Counts rising edges of s_ready (one per holding-register transfer).
    int   ready_rises = 0;
    logic ready_prev  = 1'b1;
    always @(posedge aud_mclk) begin
        ready_prev <= s_ready;
        if (s_ready && !ready_prev) ready_rises <= ready_rises + 1;
    end

    typedef struct {
        logic [7:0]  div;
        logic [23:0] l;
        logic [23:0] r;
        int          half;
        logic [63:0] data;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge aud_mclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] status();
        return 64'({sclk_out, lrclk_out, sdata_0_out, irq, busy, s_ready});
    endfunction

    // Records sdata/lrclk at the next 64 fall ticks and the SCLK half-periods between them.
    task automatic capture(output logic [63:0] d, output logic [63:0] lr, output int hmin,
                           output int hmax, output logic irq0, output logic to);
        logic prev;
        int   n;
        int   run;
        int   guard;
        d = '0; lr = '0; hmin = 1000; hmax = 0; irq0 = 1'b0;
        n = 0; run = 0; guard = 0;
        prev = sclk_out;
        while (n < 64 && guard < 20000) begin
            tick();
            guard++;
            run++;
            if (sclk_out != prev) begin
                if (n > 0) begin
                    if (run < hmin) hmin = run;
                    if (run > hmax) hmax = run;
                end
                run = 0;
                if (prev && !sclk_out) begin
                    if (n == 0) irq0 = irq;
                    d[63-n]  = sdata_0_out;
                    lr[63-n] = lrclk_out;
                    n++;
                end
            end
            prev = sclk_out;
        end
        to = (n < 64);
    endtask

    task automatic watch(input int cycles, output int edges);
        logic prev;
        edges = 0;
        prev  = sclk_out;
        repeat (cycles) begin
            tick();
            if (sclk_out != prev) edges++;
            prev = sclk_out;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (busy) n = -1;
    endtask

    // Returns just after lrclk falls, so the next fall tick starts a frame.
    task automatic sync_frame(output logic to);
        logic prev;
        int   guard;
        guard = 0;
        prev  = lrclk_out;
        to    = 1'b1;
        while (guard < 5000) begin
            tick();
            guard++;
            if (prev && !lrclk_out) begin
                to = 1'b0;
                break;
            end
            prev = lrclk_out;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [63:0] lr;
        int          hmin;
        int          hmax;
        logic        irq0;
        logic        to;
        int          n;
        int          edges;
        int          r0;

        vecs[0] = '{div: 8'd2, l: 24'hA5A5A5, r: 24'h5A5A5A, half: 2, data: 64'hA5A5A500_5A5A5A00};
        vecs[1] = '{div: 8'd0, l: 24'hFFFFFF, r: 24'h000001, half: 1, data: 64'hFFFFFF00_00000100};
        vecs[2] = '{div: 8'd1, l: 24'h800000, r: 24'h123456, half: 1, data: 64'h80000000_12345600};
        vecs[3] = '{div: 8'd3, l: 24'h000000, r: 24'hFFFFFF, half: 3, data: 64'h00000000_FFFFFF00};

        aud_mrst = 1'b1; enable = 1'b0; sclk_div = 8'd0; s_valid = 1'b0;
        s_left = '0; s_right = '0; irq_clr = 1'b0;
        repeat (3) tick();
        check("reset_status", status(), 64'h01);
        aud_mrst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            sclk_div = vecs[i].div; s_left = vecs[i].l; s_right = vecs[i].r;
            s_valid = 1'b1; enable = 1'b1;
            tick();
            s_valid = 1'b0;
            capture(d, lr, hmin, hmax, irq0, to);
            enable = 1'b0;
            check($sformatf("vec%0d_timeout", i), 64'(to), 64'(0));
            check($sformatf("vec%0d_data", i), d, vecs[i].data);
            check($sformatf("vec%0d_lrclk", i), lr, LR_PATTERN);
            check($sformatf("vec%0d_half_min", i), 64'(hmin), 64'(vecs[i].half));
            check($sformatf("vec%0d_half_max", i), 64'(hmax), 64'(vecs[i].half));
            wait_idle(n);
            check($sformatf("vec%0d_idle_status", i), status(), 64'h01);
        end

        // Continuous streaming with s_valid held high.
        sclk_div = 8'd1; s_left = 24'hC0FFEE; s_right = 24'h123ABC;
        s_valid = 1'b1; enable = 1'b1;
        tick();
        r0 = ready_rises;
        for (int f = 0; f < 4; f++) begin
            capture(d, lr, hmin, hmax, irq0, to);
            check($sformatf("stream%0d_data", f), d, 64'hC0FFEE00_123ABC00);
        end
        s_valid = 1'b0;
        check("stream_ready_pulses", 64'(ready_rises - r0), 64'(4));
        check("stream_irq", 64'(irq), 64'(0));

        // Holding still has one pair, then underflow.
        capture(d, lr, hmin, hmax, irq0, to);
        check("last_pair_data", d, 64'hC0FFEE00_123ABC00);
        check("last_pair_irq0", 64'(irq0), 64'(0));
        capture(d, lr, hmin, hmax, irq0, to);
        check("underflow_data", d, 64'h0);
        check("underflow_irq0", 64'(irq0), 64'(1));
        irq_clr = 1'b1;
        tick();
        check("irq_cleared", 64'(irq), 64'(0));
        tick();
        irq_clr = 1'b0;
        check("irq_set_wins", 64'(irq), 64'(1));
        check("set_wins_on_fall", 64'(sclk_out), 64'(0));

        // Drain at p=10, re-enable at p=40 without losing SCLK edges.
        s_left = 24'hABCDEF; s_right = 24'hFEDCBA; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (19) tick();
        enable = 1'b0;
        watch(60, edges);
        check("drain_sclk_edges", 64'(edges), 64'(60));
        enable = 1'b1;
        sync_frame(to);
        check("resync_timeout", 64'(to), 64'(0));
        capture(d, lr, hmin, hmax, irq0, to);
        check("reenable_data", d, 64'hABCDEF00_FEDCBA00);
        check("reenable_half_max", 64'(hmax), 64'(1));

        // Drain from p=10 completes the frame through p=63.
        irq_clr = 1'b1; s_left = 24'h111111; s_right = 24'h222222; s_valid = 1'b1;
        tick();
        irq_clr = 1'b0; s_valid = 1'b0;
        check("irq_clr_pulse", 64'(irq), 64'(0));
        repeat (21) tick();
        enable = 1'b0;
        wait_idle(n);
        check("drain_cycles", 64'(n), 64'(108));
        check("drain_idle_status", status(), 64'h01);

        // sclk_div change while busy is ignored until the next IDLE exit.
        sclk_div = 8'd1; s_left = 24'h13579B; s_right = 24'h2468AC;
        s_valid = 1'b1; enable = 1'b1;
        tick();
        s_valid = 1'b0; sclk_div = 8'd5;
        capture(d, lr, hmin, hmax, irq0, to);
        check("div_hold_half_max", 64'(hmax), 64'(1));
        check("div_hold_data", d, 64'h13579B00_2468AC00);
        enable = 1'b0;
        wait_idle(n);
        s_left = 24'hDEAD12; s_right = 24'h00BEEF; s_valid = 1'b1; enable = 1'b1;
        tick();
        s_valid = 1'b0;
        capture(d, lr, hmin, hmax, irq0, to);
        check("div5_half_min", 64'(hmin), 64'(5));
        check("div5_half_max", 64'(hmax), 64'(5));
        check("div5_data", d, 64'hDEAD1200_00BEEF00);

        // Asynchronous reset in the right slot, then wait in PRIME.
        n = 0;
        while (!lrclk_out && n < 5000) begin
            tick();
            n++;
        end
        check("right_slot_reached", 64'(lrclk_out), 64'(1));
        repeat (30) tick();
        #3;
        aud_mrst = 1'b1;
        #1;
        check("async_reset_status", status(), 64'h01);
        tick();
        aud_mrst = 1'b0;
        watch(50, edges);
        check("prime_no_edges", 64'(edges), 64'(0));
        check("prime_busy", 64'(busy), 64'(1));
        s_left = 24'hABC123; s_right = 24'h321CBA; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        capture(d, lr, hmin, hmax, irq0, to);
        check("post_reset_data", d, 64'hABC12300_321CBA00);
        check("post_reset_half", 64'(hmax), 64'(5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
